// File: rtl/s3ga_cfg_loader.sv
// Wishbone slave that queues config words and shifts them NCH bits/cycle into the fabric chains, then strobes latch.
// Latency: ack one cycle after request; first chain bit two cycles after go (FETCH then SHIFT), one bubble per word.
// Backpressure: none on Wishbone (always acks); an empty FIFO stalls the shift, a full FIFO drops DATA writes and flags overflow.
module s3ga_cfg_loader #(
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic [31:0]      wbs_dat_o,
    output logic             wbs_ack_o,
    output logic             cfg_en_o,
    output logic [NCH-1:0]   cfg_do_o,
    output logic             cfg_we_o,
    output logic             irq_o
);
    localparam int SPW = 32 / NCH;              // shift cycles per word
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int SW  = $clog2(SPW + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [31:0]      sh_q, sh_d;
    logic [SW-1:0]    slc_q, slc_d;
    logic [LEN_W-1:0] len_q;
    logic             irq_en_q, done_q, ovf_q;
    logic             ack_q;
    logic [31:0]      dat_q, rdata;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [CW-1:0]    cnt_q;
    logic             done_set;

    // Byte selects and undecoded address bits have no effect on this block.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    logic       access, wr, rd;
    logic [1:0] adr;
    assign access = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr     = access & wbs_we_i;
    assign rd     = access & ~wbs_we_i;
    assign adr    = wbs_adr_i[3:2];

    logic ctrl_wr, len_wr, data_wr, stat_wr, go, abort;
    assign ctrl_wr = wr && (adr == 2'd0);
    assign len_wr  = wr && (adr == 2'd1);
    assign data_wr = wr && (adr == 2'd2);
    assign stat_wr = wr && (adr == 2'd3);
    assign go      = ctrl_wr & wbs_dat_i[0];
    assign abort   = ctrl_wr & wbs_dat_i[1];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted then.
    logic fifo_ne, fifo_full, pop, push, busy;
    assign fifo_ne   = (cnt_q != '0);
    assign fifo_full = (cnt_q == CW'(FIFO_DEPTH));
    assign pop       = (state_q == S_FETCH) && fifo_ne && !abort;
    assign push      = data_wr && (!fifo_full || pop);
    assign busy      = (state_q != S_IDLE);

    // Job sequencing: fetch a word, shift its slices LSB-first, latch when the count runs out.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        sh_d     = sh_q;
        slc_d    = slc_q;
        done_set = 1'b0;
        case (state_q)
            S_IDLE: if (go) begin
                rem_d   = len_q;
                state_d = (len_q == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: if (fifo_ne) begin
                sh_d    = mem_q[rp_q];
                slc_d   = SW'(SPW);
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                sh_d  = sh_q >> NCH;
                rem_d = rem_q - LEN_W'(1);
                slc_d = slc_q - SW'(1);
                if (rem_q == LEN_W'(1))
                    state_d = S_LATCH;      // leftover slices of this word are discarded
                else if (slc_q == SW'(1))
                    state_d = S_FETCH;
            end
            S_LATCH: state_d = S_DONE;
            S_DONE: begin
                done_set = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            done_set = 1'b0;
        end
    end

    // FSM and shift datapath registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            sh_q    <= '0;
            slc_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sh_q    <= sh_d;
            slc_q   <= slc_d;
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wp_q] <= wbs_dat_i;
    end

    // FIFO pointers and occupancy; abort flushes everything queued.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else if (abort) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Control registers and sticky flags; a set in the same cycle as W1C wins.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            len_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (len_wr)  len_q    <= wbs_dat_i[LEN_W-1:0];
            if (ctrl_wr) irq_en_q <= wbs_dat_i[2];
            if (done_set)                     done_q <= 1'b1;
            else if (stat_wr && wbs_dat_i[1]) done_q <= 1'b0;
            if (data_wr && !push)             ovf_q  <= 1'b1;
            else if (stat_wr && wbs_dat_i[2]) ovf_q  <= 1'b0;
        end
    end

    // Read mux, registered together with the ack.
    always_comb begin
        rdata = '0;
        case (adr)
            2'd0:    rdata = {29'b0, irq_en_q, 2'b0};
            2'd1:    rdata = 32'(len_q);
            2'd3:    rdata = {16'b0, 8'(cnt_q), 5'b0, ovf_q, done_q, busy};
            default: rdata = '0;
        endcase
    end

    // Single-cycle ack for every access, no wait states.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= access;
            dat_q <= rd ? rdata : '0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign cfg_en_o  = (state_q == S_SHIFT);
    assign cfg_do_o  = cfg_en_o ? sh_q[NCH-1:0] : '0;
    assign cfg_we_o  = (state_q == S_LATCH);
    assign irq_o     = done_q & irq_en_q;
endmodule

// File: tb/tb_s3ga_cfg_loader.sv
// Directed bench for s3ga_cfg_loader: Wishbone register accesses plus a slice scoreboard on the chain outputs.
// Latency: expected slices are queued when words are written and popped on every cfg_en_o cycle.
// Backpressure: waits on the DUT are bounded by cycle budgets; an expired budget is a failed check.
module tb_s3ga_cfg_loader;
    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic [31:0] rdat;
    logic        ack, cfg_en, cfg_we, irq;
    logic [NCH-1:0] cfg_do;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int we_cnt = 0;
    logic [NCH-1:0] exp_q[$];

    always #5 clk = ~clk;

    s3ga_cfg_loader #(.NCH(NCH), .FIFO_DEPTH(8), .LEN_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
        .cfg_en_o(cfg_en), .cfg_do_o(cfg_do), .cfg_we_o(cfg_we), .irq_o(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one expected slice per shift-enable cycle.
    always @(negedge clk) begin
        if (cfg_en) begin
            en_cnt++;
            if (exp_q.size() != 0) chk("slice", {28'b0, cfg_do}, {28'b0, exp_q.pop_front()});
            else chk("unexpected_shift", {28'b0, cfg_do}, 32'hxxxx_xxxx);
        end
        if (cfg_we) we_cnt++;
    end

    task automatic push_exp(input logic [31:0] w, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(NCH'(w >> (NCH * k)));
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {28'b0, a, 2'b0}; wdat = d;
        @(negedge clk);
        chk("wr_ack", {31'b0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {28'b0, a, 2'b0};
        @(negedge clk);
        chk("rd_ack", {31'b0, ack}, 32'd1);
        chk(tag, rdat, exp);
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_we(input string tag, input int budget);
        int i;
        for (i = 0; i < budget && !cfg_we; i++) @(negedge clk);
        chk(tag, {31'b0, i < budget}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic push_word(input logic [31:0] w, input int n);
        push_exp(w, n);
        wb_wr(2'd2, w);
    endtask

    initial begin
        int base_en, base_we, n, t;
        repeat (2) @(negedge clk);
        chk("rst_en", {31'b0, cfg_en}, 32'd0);
        chk("rst_we", {31'b0, cfg_we}, 32'd0);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        rst_n = 1'b1;
        wb_rd_chk("rst_status", 2'd3, 32'h0);
        wb_rd_chk("rst_len", 2'd1, 32'h0);

        // Main job: 16 shifts across two words, then a single latch and irq.
        wb_wr(2'd0, 32'h4);
        wb_wr(2'd1, 32'd16);
        wb_rd_chk("len_rb", 2'd1, 32'd16);
        push_word(32'h8765_4321, 8);
        push_word(32'h0FED_CBA9, 8);
        base_en = en_cnt; base_we = we_cnt;
        wb_wr(2'd0, 32'h5);
        wait_we("main_latch_timeout", 100);
        chk("main_shifts", en_cnt - base_en, 16);
        chk("main_latch", we_cnt - base_we, 1);
        chk("main_sb_empty", exp_q.size(), 0);
        wb_rd_chk("main_status", 2'd3, 32'h2);
        chk("main_irq", {31'b0, irq}, 32'd1);
        wb_wr(2'd3, 32'h2);
        chk("irq_clr", {31'b0, irq}, 32'd0);

        // Overflow: nine words into eight entries.
        for (int k = 0; k < 9; k++) wb_wr(2'd2, 32'hA000_0000 + k);
        wb_rd_chk("ovf_status", 2'd3, 32'h804);
        wb_wr(2'd3, 32'h4);
        wb_rd_chk("ovf_clr", 2'd3, 32'h800);
        wb_wr(2'd0, 32'h6);
        wb_rd_chk("flush_status", 2'd3, 32'h0);

        // Underrun stall: one word for a 16-shift job.
        base_en = en_cnt; base_we = we_cnt;
        push_word(32'h1357_9BDF, 8);
        wb_wr(2'd0, 32'h5);
        repeat (20) @(negedge clk);
        chk("stall_shifts", en_cnt - base_en, 8);
        chk("stall_en_low", {31'b0, cfg_en}, 32'd0);
        wb_rd_chk("stall_busy", 2'd3, 32'h1);
        push_word(32'h2468_ACE0, 8);
        wait_we("stall_latch_timeout", 100);
        chk("stall_total", en_cnt - base_en, 16);
        chk("stall_latch", we_cnt - base_we, 1);
        wb_rd_chk("stall_status", 2'd3, 32'h2);
        wb_wr(2'd3, 32'h2);

        // Abort after exactly five shifts of a 32-shift job.
        wb_wr(2'd1, 32'd32);
        for (int k = 0; k < 4; k++) push_word(32'h1111_1111 * (k + 1), 8);
        base_en = en_cnt; base_we = we_cnt;
        wb_wr(2'd0, 32'h5);
        n = 0; t = 0;
        while (n < 4 && t < 200) begin
            @(negedge clk);
            if (cfg_en) n++;
            t++;
        end
        chk("abort_wait", n, 4);
        wb_wr(2'd0, 32'h6);
        chk("abort_en_low", {31'b0, cfg_en}, 32'd0);
        exp_q.delete();
        repeat (10) @(negedge clk);
        chk("abort_shifts", en_cnt - base_en, 5);
        chk("abort_no_latch", we_cnt - base_we, 0);
        wb_rd_chk("abort_status", 2'd3, 32'h0);

        // LEN==0 go: done without strobes.
        wb_wr(2'd1, 32'd0);
        base_en = en_cnt; base_we = we_cnt;
        wb_wr(2'd0, 32'h5);
        repeat (5) @(negedge clk);
        chk("len0_shifts", en_cnt - base_en, 0);
        chk("len0_latch", we_cnt - base_we, 0);
        wb_rd_chk("len0_status", 2'd3, 32'h2);
        chk("len0_irq", {31'b0, irq}, 32'd1);
        wb_wr(2'd3, 32'h2);

        // go and LEN write while busy: current job keeps its count.
        wb_wr(2'd1, 32'd16);
        push_word(32'hDEAD_BEEF, 8);
        push_word(32'hCAFE_F00D, 8);
        base_en = en_cnt; base_we = we_cnt;
        wb_wr(2'd0, 32'h5);
        repeat (3) @(negedge clk);
        wb_wr(2'd1, 32'd6);
        wb_wr(2'd0, 32'h5);
        wait_we("busy_latch_timeout", 100);
        repeat (20) @(negedge clk);
        chk("busy_shifts", en_cnt - base_en, 16);
        chk("busy_latch", we_cnt - base_we, 1);
        wb_wr(2'd3, 32'h2);

        // LEN=6 with one word: last two slices dropped.
        base_en = en_cnt; base_we = we_cnt;
        push_word(32'h9ABC_DEF1, 6);
        wb_wr(2'd0, 32'h5);
        wait_we("len6_latch_timeout", 100);
        chk("len6_shifts", en_cnt - base_en, 6);
        chk("len6_latch", we_cnt - base_we, 1);
        chk("len6_sb_empty", exp_q.size(), 0);
        wb_rd_chk("len6_status", 2'd3, 32'h2);

        // Reset mid-shift.
        wb_wr(2'd1, 32'd16);
        push_word(32'h0F0F_0F0F, 8);
        push_word(32'hF0F0_F0F0, 8);
        wb_wr(2'd0, 32'h5);
        n = 0; t = 0;
        while (n < 3 && t < 200) begin
            @(negedge clk);
            if (cfg_en) n++;
            t++;
        end
        chk("rst_wait", n, 3);
        base_we = we_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", {31'b0, cfg_en}, 32'd0);
        chk("mid_rst_do", {28'b0, cfg_do}, 32'd0);
        chk("mid_rst_we", {31'b0, cfg_we}, 32'd0);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        wb_rd_chk("post_rst_status", 2'd3, 32'h0);
        wb_rd_chk("post_rst_ctrl", 2'd0, 32'h0);
        repeat (5) @(negedge clk);
        chk("post_rst_no_latch", we_cnt - base_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
